// File: rtl/fifo_rr_readout.sv
// Round-robin readout of four rcvfifo channels as one wishbone data stream.
// Optional CHWAIT timeout is enabled with `define RR_TIMEOUT_EN.
module fifo_rr_readout #(
  parameter int MAX_BLOCK = 1024,
  parameter int TIMEOUT   = 255
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  input  logic         wb_cyc,
  input  logic         wb_stb,
  input  logic         wb_we,
  input  logic         wb_adr,
  input  logic [31:0]  wb_dat_i,
  output logic [31:0]  wb_dat_o,
  output logic         wb_ack,
  input  logic [63:0]  ch_cnt,
  output logic [3:0]   ch_cyc,
  output logic [3:0]   ch_stb,
  input  logic [127:0] ch_dat,
  input  logic [3:0]   ch_ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

  localparam logic [15:0] LMAX = 16'(MAX_BLOCK);

  logic [2:0]  r_state;
  logic [2:0]  r_nxt;
  logic [1:0]  r_ch;
  logic [1:0]  r_last;
  logic [3:0]  r_mask;
  logic [15:0] r_rem;
  logic [15:0] r_len;
  logic [31:0] r_dat;
  logic        r_ack;
  logic [3:0]  r_req;
  logic        r_abort;

  logic        w_req;
  logic [3:0]  w_elig;
  logic        w_any;
  logic [1:0]  w_pick;
  logic [15:0] w_cnt_sel;
  logic [15:0] w_len;
  logic [31:0] w_chdat;
  logic        w_chack;
  logic [31:0] w_status;
  logic [15:0] w_rem_dec;
  logic        w_done;
  logic        w_abort_now;
  logic        w_tmo;
  logic        w_unused_dat;

  assign w_req = wb_cyc & wb_stb;
  assign w_unused_dat = ^wb_dat_i[30:4];

  // Eligibility: channel enabled in the mask and its FIFO holds data
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = r_mask[i] & (ch_cnt[16*i +: 16] != 16'd0);
    end
  end

  // Round-robin search starting after the last served channel
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    for (int k = 1; k <= 4; k++) begin
      if (!w_any && w_elig[r_last + 2'(k)]) begin
        w_any  = 1'b1;
        w_pick = r_last + 2'(k);
      end
    end
  end

  assign w_cnt_sel = ch_cnt[{w_pick, 4'd0} +: 16];
  assign w_len     = (w_cnt_sel > LMAX) ? LMAX : w_cnt_sel;
  assign w_chdat   = ch_dat[{r_ch, 5'd0} +: 32];
  assign w_chack   = ch_ack[r_ch];
  assign w_rem_dec = (r_rem != 16'd0) ? r_rem - 16'd1 : 16'd0;
  assign w_done    = (w_rem_dec == 16'd0);
  assign w_abort_now = r_abort | ~wb_cyc;

  // Status word: state, channel, mask, eligibility, words left in block
  assign w_status = {r_state, 1'b0, r_ch, 2'b00,
                     r_mask, w_elig, r_rem};

`ifdef RR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_tmo;

  // Counts CHWAIT cycles without a channel acknowledge
  always_ff @(posedge wb_clk) begin
    if (wb_rst || r_state != S_WAIT) begin
      r_tmo <= 16'd0;
    end else if (!w_chack) begin
      r_tmo <= r_tmo + 16'd1;
    end
  end

  assign w_tmo = (r_state == S_WAIT) & ~w_chack & (r_tmo == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT;
  assign w_tmo = 1'b0;
`endif

  // Readout state machine, wishbone slave side and channel master side
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state <= S_IDLE;
      r_nxt   <= S_IDLE;
      r_ch    <= 2'd0;
      r_last  <= 2'd3;
      r_mask  <= 4'hF;
      r_rem   <= 16'd0;
      r_len   <= 16'd0;
      r_dat   <= 32'd0;
      r_ack   <= 1'b0;
      r_req   <= 4'd0;
      r_abort <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DATA: begin
          if (w_req) begin
            if (wb_adr) begin
              r_ack   <= 1'b1;
              r_state <= S_ACK;
              r_nxt   <= r_state;
              if (wb_we) begin
                r_mask <= wb_dat_i[3:0];
                if (wb_dat_i[31]) begin
                  r_rem <= 16'd0;
                  r_nxt <= S_IDLE;
                end
              end else begin
                r_dat <= w_status;
              end
            end else if (wb_we) begin
              r_ack   <= 1'b1;
              r_state <= S_ACK;
              r_nxt   <= r_state;
            end else if (r_state == S_IDLE) begin
              if (w_any) begin
                r_ch    <= w_pick;
                r_len   <= w_len;
                r_rem   <= w_len;
                r_state <= S_HDR;
              end else begin
                r_dat   <= 32'hE000_0000;
                r_ack   <= 1'b1;
                r_state <= S_ACK;
                r_nxt   <= S_IDLE;
              end
            end else begin
              r_req   <= 4'd1 << r_ch;
              r_abort <= 1'b0;
              r_state <= S_WAIT;
            end
          end
        end
        S_HDR: begin
          r_dat   <= {4'hA, 2'b00, r_ch, 8'h00, r_len};
          r_ack   <= 1'b1;
          r_state <= S_ACK;
          r_nxt   <= S_DATA;
        end
        S_WAIT: begin
          r_abort <= w_abort_now;
          if (w_chack) begin
            r_req <= 4'd0;
            r_rem <= w_rem_dec;
            r_nxt <= w_done ? S_IDLE : S_DATA;
            if (w_done) begin
              r_last <= r_ch;
            end
            if (!w_abort_now) begin
              r_dat   <= w_chdat;
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end else if (w_req && wb_adr) begin
              r_ack   <= 1'b1;
              r_state <= S_ACK;
              if (wb_we) begin
                r_mask <= wb_dat_i[3:0];
                if (wb_dat_i[31]) begin
                  r_rem <= 16'd0;
                  r_nxt <= S_IDLE;
                end
              end else begin
                r_dat <= w_status;
              end
            end else begin
              r_state <= w_done ? S_IDLE : S_DATA;
            end
          end else if (w_tmo) begin
            r_req  <= 4'd0;
            r_dat  <= 32'hDEAD_0000 | 32'(r_ch);
            r_rem  <= 16'd0;
            r_last <= r_ch;
            r_nxt  <= S_IDLE;
            if (w_abort_now) begin
              r_state <= S_IDLE;
            end else begin
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          r_state <= r_nxt;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack   = r_ack;
  assign ch_cyc   = r_req;
  assign ch_stb   = r_req;

endmodule
